// File: rtl/drag_race_pkg.sv
// Shared types and defaults for the multi-lane drag race timer.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package drag_race_pkg;

    // Race sequencer states; the top module mirrors these as plain constants.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STAGE     = 3'd1,
        COUNTDOWN = 3'd2,
        RACE      = 3'd3,
        DONE      = 3'd4
    } race_state_e;

    localparam int TICK_DIV_DEF    = 500000; // 10 ms at 50 MHz
    localparam int TIME_MAX_DEF    = 9999;   // 99.99 s display limit
    localparam int AMBER_TICKS_DEF = 50;     // 0.5 s per amber lamp

    // Bit offset of lane 'lane' inside a packed per-lane time bus.
    function automatic int lane_lsb(input int lane, input int time_w);
        return lane * time_w;
    endfunction

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drag_race_timer_if.sv
// Lane, lamp and result signals between race logic and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// Ports: arm/clear_best/lane_* inputs to the timer; lamps, lane results,
// winner, race_done and best_time outputs. lane_react exists only when
// REACTION_TIME_EN is defined.
interface drag_race_timer_if #(
    parameter int N_LANES     = 2,
    parameter int TIME_W      = 14,
    parameter int AMBER_STEPS = 3
);
    logic                        arm;
    logic                        clear_best;
    logic [N_LANES-1:0]          lane_staged;
    logic [N_LANES-1:0]          lane_launch;
    logic [N_LANES-1:0]          lane_finish;
    logic [AMBER_STEPS-1:0]      lamp_amber;
    logic                        lamp_green;
    logic [N_LANES-1:0]          lane_red;
    logic [N_LANES-1:0]          lane_done;
    logic [N_LANES*TIME_W-1:0]   lane_time;
    logic [N_LANES-1:0]          winner;
    logic                        race_done;
    logic [TIME_W-1:0]           best_time;
`ifdef REACTION_TIME_EN
    logic [N_LANES*TIME_W-1:0]   lane_react;
`endif

    // Upstream side: sensor logic / race director.
    modport master (
`ifdef REACTION_TIME_EN
        input  lane_react,
`endif
        output arm, clear_best, lane_staged, lane_launch, lane_finish,
        input  lamp_amber, lamp_green, lane_red, lane_done, lane_time,
               winner, race_done, best_time
    );

    // Timer side.
    modport slave (
`ifdef REACTION_TIME_EN
        output lane_react,
`endif
        input  arm, clear_best, lane_staged, lane_launch, lane_finish,
        output lamp_amber, lamp_green, lane_red, lane_done, lane_time,
               winner, race_done, best_time
    );

endinterface

// File: rtl/drag_tick_prescaler.sv
// Divides clk_in down to a single-cycle timing tick every TICK_DIV cycles.
// Latency: first tick TICK_DIV cycles after zero_i is released.
// Backpressure: none; free-running, restarted by zero_i.
// Ports: clk_in/rst clock and async reset, zero_i synchronous restart,
// tick_o one-cycle pulse on the last count of each period.
module drag_tick_prescaler
    import drag_race_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic zero_i,
    output logic tick_o
);

    localparam int              CW   = clog2_min1(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (zero_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A restart cycle never emits a tick, so a new period is always full length.
    assign tick_o = !zero_i && (cnt_q == LAST);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/drag_race_timer.sv
// Multi-lane drag race controller: start tree, false starts, lane timing, winner, best time.
// Latency: outputs are registered state; a finish is visible on lane_done/winner one cycle later.
// Backpressure: none; inputs are sampled every cycle, arm outside IDLE/DONE is dropped.
// Ports: clk_in, rst (async, active high) and the slave side of drag_race_timer_if.
// Optional build macro REACTION_TIME_EN adds per-lane reaction time on bus.lane_react.
module drag_race_timer
    import drag_race_pkg::*;
#(
    parameter int N_LANES     = 2,
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int TIME_W      = 14,
    parameter int TIME_MAX    = TIME_MAX_DEF,
    parameter int AMBER_STEPS = 3,
    parameter int AMBER_TICKS = AMBER_TICKS_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    drag_race_timer_if.slave  bus
);

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_STAGE     = STAGE;
    localparam logic [2:0] S_COUNTDOWN = COUNTDOWN;
    localparam logic [2:0] S_RACE      = RACE;
    localparam logic [2:0] S_DONE      = DONE;

    localparam int                SW   = clog2_min1(AMBER_STEPS);
    localparam int                AW   = clog2_min1(AMBER_TICKS);
    localparam logic [TIME_W-1:0] TMAX = TIME_W'(TIME_MAX);

    logic [2:0]          state_q, state_d;
    logic [SW-1:0]       stage_q, stage_d;   // current amber lamp
    logic [AW-1:0]       atick_q, atick_d;   // ticks spent in current amber lamp
    logic [N_LANES-1:0]  red_q, red_d;
    logic [N_LANES-1:0]  done_q, done_d;
    logic [N_LANES-1:0]  win_q, win_d;
    logic [TIME_W-1:0]   time_q [N_LANES];
    logic [TIME_W-1:0]   time_d [N_LANES];
    logic [TIME_W-1:0]   best_q, best_d;

    logic                tick;
    logic                presc_zero;
    logic [N_LANES-1:0]  fin_v;     // lanes validly finishing this cycle
    logic [TIME_W-1:0]   win_time;  // lowest time among this cycle's finishers
    logic                start_race;

    drag_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_in (clk_in),
        .rst    (rst),
        .zero_i (presc_zero),
        .tick_o (tick)
    );

    assign start_race = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.arm;

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        atick_d    = atick_q;
        red_d      = red_q;
        done_d     = done_q;
        win_d      = win_q;
        time_d     = time_q;
        best_d     = best_q;
        presc_zero = 1'b0;
        fin_v      = '0;
        win_time   = TMAX;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.arm) begin
                    state_d = S_STAGE;
                    red_d   = '0;
                    done_d  = '0;
                    win_d   = '0;
                    for (int i = 0; i < N_LANES; i++) begin
                        time_d[i] = '0;
                    end
                end
            end

            S_STAGE, S_COUNTDOWN: begin
                for (int i = 0; i < N_LANES; i++) begin
                    if (!red_q[i] && (bus.lane_launch[i] || !bus.lane_staged[i])) begin
                        red_d[i]  = 1'b1;
                        done_d[i] = 1'b1;
                        time_d[i] = TMAX;
                    end
                end

                if (&red_d) begin
                    // Nobody left to race: skip the tree entirely, winner stays 0.
                    state_d = S_DONE;
                end else if (state_q == S_STAGE) begin
                    // A lane still unstaged here has just been red-lit, so it
                    // cannot hold the tree for the rest of the field.
                    if (&(bus.lane_staged | red_d)) begin
                        state_d    = S_COUNTDOWN;
                        presc_zero = 1'b1;
                        stage_d    = '0;
                        atick_d    = '0;
                    end
                end else if (tick) begin
                    if (atick_q == AW'(AMBER_TICKS - 1)) begin
                        atick_d = '0;
                        if (stage_q == SW'(AMBER_STEPS - 1)) begin
                            state_d = S_RACE;
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end else begin
                        atick_d = atick_q + 1'b1;
                    end
                end
            end

            S_RACE: begin
                if (&done_q) begin
                    state_d = S_DONE;
                end
                for (int i = 0; i < N_LANES; i++) begin
                    if (!done_q[i]) begin
                        if (bus.lane_finish[i]) begin
                            // Finish wins over a same-cycle tick: time freezes as is.
                            done_d[i] = 1'b1;
                            fin_v[i]  = 1'b1;
                            if (time_q[i] < win_time) begin
                                win_time = time_q[i];
                            end
                        end else if (tick) begin
                            time_d[i] = time_q[i] + 1'b1;
                            if (time_q[i] == TMAX - 1'b1) begin
                                done_d[i] = 1'b1;   // timeout, never a winner
                            end
                        end
                    end
                end
                // Only the first finishing cycle of a race names the winner(s).
                if ((win_q == '0) && (fin_v != '0)) begin
                    win_d = fin_v;
                    if (win_time < best_q) begin
                        best_d = win_time;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.clear_best) begin
            best_d = TMAX;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            atick_q <= '0;
            red_q   <= '0;
            done_q  <= '0;
            win_q   <= '0;
            best_q  <= TMAX;
            for (int i = 0; i < N_LANES; i++) begin
                time_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            atick_q <= atick_d;
            red_q   <= red_d;
            done_q  <= done_d;
            win_q   <= win_d;
            best_q  <= best_d;
            time_q  <= time_d;
        end
    end

    always_comb begin
        bus.lamp_amber = '0;
        if (state_q == S_COUNTDOWN) begin
            bus.lamp_amber = AMBER_STEPS'(1) << stage_q;
        end
        bus.lamp_green = (state_q == S_RACE);
        bus.race_done  = (state_q == S_DONE);
        bus.lane_red   = red_q;
        bus.lane_done  = done_q;
        bus.winner     = win_q;
        bus.best_time  = best_q;
        bus.lane_time  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            bus.lane_time[lane_lsb(i, TIME_W) +: TIME_W] = time_q[i];
        end
    end

`ifdef REACTION_TIME_EN
    // Reaction time: ticks from green onset until the lane first launches.
    logic [TIME_W-1:0]  react_q [N_LANES];
    logic [TIME_W-1:0]  react_d [N_LANES];
    logic [N_LANES-1:0] launched_q, launched_d;

    always_comb begin
        react_d    = react_q;
        launched_d = launched_q;
        if (start_race) begin
            launched_d = '0;
            for (int i = 0; i < N_LANES; i++) begin
                react_d[i] = '0;
            end
        end else if (state_q == S_RACE) begin
            for (int i = 0; i < N_LANES; i++) begin
                // Red-lit lanes never count and so keep reporting 0.
                if (!red_q[i] && !launched_q[i]) begin
                    if (bus.lane_launch[i]) begin
                        launched_d[i] = 1'b1;
                    end else if (tick && (react_q[i] != TMAX)) begin
                        react_d[i] = react_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            launched_q <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                react_q[i] <= '0;
            end
        end else begin
            launched_q <= launched_d;
            react_q    <= react_d;
        end
    end

    always_comb begin
        bus.lane_react = '0;
        for (int i = 0; i < N_LANES; i++) begin
            bus.lane_react[lane_lsb(i, TIME_W) +: TIME_W] = react_q[i];
        end
    end
`else
    // start_race only feeds the reaction-time counters.
    logic unused_start_race;
    assign unused_start_race = start_race;
`endif

endmodule

// File: tb/tb_drag_race_timer.sv
// Scoreboard bench for drag_race_timer: directed races plus randomized races.
// Latency: n/a.
// Backpressure: n/a.
module tb_drag_race_timer;

    localparam int NL    = 2;
    localparam int TW    = 14;
    localparam int TDIV  = 4;
    localparam int TMAX  = 20;
    localparam int ASTEP = 3;
    localparam int ATICK = 2;
    localparam int CD_CYCLES = ASTEP * ATICK * TDIV;   // countdown length in clocks

    typedef struct packed {
        logic [NL-1:0]    win;
        logic [NL-1:0]    red;
        logic [NL-1:0]    done;
        logic [NL*TW-1:0] times;
        logic [TW-1:0]    best;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_best = TMAX;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    drag_race_timer_if #(.N_LANES(NL), .TIME_W(TW), .AMBER_STEPS(ASTEP)) bus ();

    drag_race_timer #(
        .N_LANES     (NL),
        .TICK_DIV    (TDIV),
        .TIME_W      (TW),
        .TIME_MAX    (TMAX),
        .AMBER_STEPS (ASTEP),
        .AMBER_TICKS (ATICK)
    ) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Checked after an async reset: everything zero except best_time.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_amber"},  32'(bus.lamp_amber), 32'(0));
        check({tag, "_green"},  32'(bus.lamp_green), 32'(0));
        check({tag, "_red"},    32'(bus.lane_red),   32'(0));
        check({tag, "_done"},   32'(bus.lane_done),  32'(0));
        check({tag, "_time"},   32'(bus.lane_time),  32'(0));
        check({tag, "_winner"}, 32'(bus.winner),     32'(0));
        check({tag, "_rdone"},  32'(bus.race_done),  32'(0));
        check({tag, "_best"},   32'(bus.best_time),  32'(TMAX));
    endtask

    // One race. c[i] = green-relative clock index (1 = first green cycle) at which
    // lane i raises finish, 0 = never. Lane time at finish = ticks completed before
    // that clock = (c-1)/TDIV. Red lanes launch during amber stage red_stage.
    task automatic run_race(input logic [NL-1:0] red_mask, input int red_stage,
                            input int c0, input int c1, input bit arm_cd,
                            input bit clr_win, input int abort_k);
        int c[NL];
        int k, amb_cyc, cmin, tv;
        bit red_done, armed_cd, finished;
        logic [ASTEP-1:0] amb_sel;
        exp_t e;

        c[0] = c0;
        c[1] = c1;
        amb_sel = 3'b001 << red_stage;

        e.red  = red_mask;
        e.done = '1;
        e.win  = '0;
        e.times = '0;
        cmin = 0;
        for (int i = 0; i < NL; i++) begin
            tv = (red_mask[i] || c[i] == 0) ? TMAX : (c[i] - 1) / TDIV;
            e.times[i*TW +: TW] = TW'(tv);
            if (!red_mask[i] && c[i] > 0 && (cmin == 0 || c[i] < cmin)) cmin = c[i];
        end
        for (int i = 0; i < NL; i++) begin
            if (!red_mask[i] && cmin > 0 && c[i] == cmin) e.win[i] = 1'b1;
        end
        if (cmin > 0) begin
            if (clr_win) model_best = TMAX;
            else if ((cmin - 1) / TDIV < model_best) model_best = (cmin - 1) / TDIV;
        end
        e.best = TW'(model_best);
        if (abort_k == 0) exp_q.push_back(e);

        @(negedge clk);
        bus.lane_staged = '1;
        bus.lane_launch = '0;
        bus.lane_finish = '0;
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;

        k = 0;
        amb_cyc = 0;
        red_done = 1'b0;
        armed_cd = 1'b0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            bus.arm = 1'b0;
            bus.clear_best = 1'b0;
            if (bus.race_done) begin
                finished = 1'b1;
            end else begin
                if (bus.lamp_amber != '0) begin
                    amb_cyc++;
                    if (amb_cyc == 1) check("first_amber", 32'(bus.lamp_amber), 32'(1));
                    if (red_mask != '0 && !red_done && bus.lamp_amber == amb_sel) begin
                        bus.lane_launch = red_mask;
                        red_done = 1'b1;
                    end
                    if (arm_cd && !armed_cd && amb_cyc == 5) begin
                        bus.arm = 1'b1;
                        armed_cd = 1'b1;
                    end
                end
                if (bus.lamp_green) begin
                    k++;
                    if (k == 1) begin
                        check("countdown_len", 32'(amb_cyc), 32'(CD_CYCLES));
                        check("amber_off_in_green", 32'(bus.lamp_amber), 32'(0));
                    end
                    if (abort_k != 0 && k == abort_k) begin
                        rst = 1'b1;
                        #1;
                        check_reset_outputs("midrace_rst");
                        @(negedge clk);
                        rst = 1'b0;
                        bus.lane_launch = '0;
                        bus.lane_finish = '0;
                        return;
                    end
                    for (int i = 0; i < NL; i++) begin
                        if (!red_mask[i]) bus.lane_launch[i] = 1'b1;
                        if (!red_mask[i] && c[i] > 0 && k >= c[i]) bus.lane_finish[i] = 1'b1;
                    end
                    if (clr_win && k == cmin) bus.clear_best = 1'b1;
                end
                @(negedge clk);
            end
        end
        check("race_completes", 32'(finished), 32'(1));
        if (&red_mask) check("no_green_all_red", 32'(k), 32'(0));
        bus.lane_launch = '0;
        bus.lane_finish = '0;
    endtask

    // Monitor: compare the scoreboard entry whenever a race result is presented.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.race_done && !prev_done) begin
                check("result_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("winner",    32'(bus.winner),    32'(e.win));
                    check("lane_red",  32'(bus.lane_red),  32'(e.red));
                    check("lane_done", 32'(bus.lane_done), 32'(e.done));
                    check("lane_time", 32'(bus.lane_time), 32'(e.times));
                    check("best_time", 32'(bus.best_time), 32'(e.best));
                end
            end
            prev_done = bus.race_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.arm = 1'b0;
        bus.clear_best = 1'b0;
        bus.lane_staged = '0;
        bus.lane_launch = '0;
        bus.lane_finish = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_rdone", 32'(bus.race_done), 32'(0));

        // 1: lane0 at tick 7, lane1 at tick 9
        run_race(2'b00, 0, 7*TDIV + 1, 9*TDIV + 3, 1'b0, 1'b0, 0);
        // 2: lane1 false start in amber stage 1, lane0 at tick 5
        run_race(2'b10, 1, 5*TDIV + 1, 0, 1'b0, 1'b0, 0);
        // 3: tie at tick 6
        run_race(2'b00, 0, 6*TDIV + 2, 6*TDIV + 2, 1'b0, 1'b0, 0);
        // 4: both time out
        run_race(2'b00, 0, 0, 0, 1'b0, 1'b0, 0);
        // 5: reset at tick 3 of RACE, then a race won at 12, then clear_best
        run_race(2'b00, 0, 0, 0, 1'b0, 1'b0, 3*TDIV + 1);
        model_best = TMAX;
        run_race(2'b00, 0, 12*TDIV + 3, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        bus.clear_best = 1'b1;
        @(negedge clk);
        bus.clear_best = 1'b0;
        model_best = TMAX;
        check("clear_best_done", 32'(bus.best_time), 32'(TMAX));
        // 6: arm during countdown ignored; clear_best same cycle as winner at 4
        run_race(2'b00, 0, 4*TDIV + 1, 0, 1'b1, 1'b1, 0);
        // all lanes red-lit
        run_race(2'b11, 2, 0, 0, 1'b0, 1'b0, 0);

        for (int r = 0; r < 12; r++) begin
            logic [NL-1:0] rm;
            int rc0, rc1;
            rm  = ($urandom_range(0, 3) == 0) ? NL'($urandom_range(1, 3)) : '0;
            rc0 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TMAX*TDIV));
            rc1 = ($urandom_range(0, 3) == 0) ? rc0 :
                  (($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TMAX*TDIV)));
            run_race(rm, int'($urandom_range(0, ASTEP-1)), rc0, rc1, 1'b0, 1'b0, 0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
